// File: rtl/alu_exec_unit_pkg.sv
// rtl/alu_exec_unit_pkg.sv - shared constants, op codes and result record for the integer execution unit
//
// Holds the word width, ROB tag width, issue op-code encoding and the packed
// record that travels down the ALU result pipeline.
package alu_exec_unit_pkg;

  localparam int XLEN     = 32;
  localparam int ROB_ID_W = 5;
  localparam int OP_W     = 7;

  // Codes 11..18 belong to the load/store buffer and never reach the ALU result path.
  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 7'd0,
    OP_LUI   = 7'd1,
    OP_AUIPC = 7'd2,
    OP_JAL   = 7'd3,
    OP_JALR  = 7'd4,
    OP_BEQ   = 7'd5,
    OP_BNE   = 7'd6,
    OP_BLT   = 7'd7,
    OP_BGE   = 7'd8,
    OP_BLTU  = 7'd9,
    OP_BGEU  = 7'd10,
    OP_ADDI  = 7'd19,
    OP_SLTI  = 7'd20,
    OP_SLTIU = 7'd21,
    OP_XORI  = 7'd22,
    OP_ORI   = 7'd23,
    OP_ANDI  = 7'd24,
    OP_SLLI  = 7'd25,
    OP_SRLI  = 7'd26,
    OP_SRAI  = 7'd27,
    OP_ADD   = 7'd28,
    OP_SUB   = 7'd29,
    OP_SLL   = 7'd30,
    OP_SLT   = 7'd31,
    OP_SLTU  = 7'd32,
    OP_XOR   = 7'd33,
    OP_SRL   = 7'd34,
    OP_SRA   = 7'd35,
    OP_OR    = 7'd36,
    OP_AND   = 7'd37
  } alu_op_e;

  typedef struct packed {
    logic                valid;
    logic [XLEN-1:0]     res;
    logic [ROB_ID_W-1:0] rob_id;
    logic                is_br;
    logic                taken;
    logic [XLEN-1:0]     next_pc;
  } alu_result_t;

endpackage

// File: rtl/alu_compute.sv
// rtl/alu_compute.sv - combinational RV32I result and branch/jump resolution
//
// Ports:
//   op      in  7   issued op code
//   vi, vj  in  32  rs1 / rs2 operand values
//   imm     in  32  sign-extended immediate
//   pc      in  32  instruction pc
//   res     out 32  integer result (0 for branches and invalid codes)
//   taken   out 1   control transfer taken
//   next_pc out 32  resolved next pc (pc+4 for non-control ops, 0 when invalid)
//   is_br   out 1   op is JAL/JALR/Bxx
//   valid   out 1   op produces a broadcast
module alu_compute
  import alu_exec_unit_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] vi,
  input  logic [XLEN-1:0] vj,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] res,
  output logic            taken,
  output logic [XLEN-1:0] next_pc,
  output logic            is_br,
  output logic            valid
);

  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_plus_imm;
  logic [4:0]      shamt_i;
  logic [4:0]      shamt_r;
  logic            br_cond;

  assign pc_plus4    = pc + 32'd4;
  assign pc_plus_imm = pc + imm;
  assign shamt_i     = imm[4:0];
  assign shamt_r     = vj[4:0];

  always_comb begin
    br_cond = 1'b0;
    case (op)
      OP_BEQ:  br_cond = (vi == vj);
      OP_BNE:  br_cond = (vi != vj);
      OP_BLT:  br_cond = ($signed(vi) <  $signed(vj));
      OP_BGE:  br_cond = ($signed(vi) >= $signed(vj));
      OP_BLTU: br_cond = (vi <  vj);
      OP_BGEU: br_cond = (vi >= vj);
      default: br_cond = 1'b0;
    endcase
  end

  always_comb begin
    res     = '0;
    taken   = 1'b0;
    next_pc = pc_plus4;
    is_br   = 1'b0;
    valid   = 1'b1;
    case (op)
      OP_LUI:   res = imm;
      OP_AUIPC: res = pc_plus_imm;
      OP_JAL: begin
        res     = pc_plus4;
        next_pc = pc_plus_imm;
        taken   = 1'b1;
        is_br   = 1'b1;
      end
      OP_JALR: begin
        res     = pc_plus4;
        next_pc = (vi + imm) & ~32'd1;
        taken   = 1'b1;
        is_br   = 1'b1;
      end
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
        is_br   = 1'b1;
        taken   = br_cond;
        next_pc = br_cond ? pc_plus_imm : pc_plus4;
      end
      OP_ADDI:  res = vi + imm;
      OP_SLTI:  res = {31'd0, $signed(vi) < $signed(imm)};
      OP_SLTIU: res = {31'd0, vi < imm};
      OP_XORI:  res = vi ^ imm;
      OP_ORI:   res = vi | imm;
      OP_ANDI:  res = vi & imm;
      OP_SLLI:  res = vi << shamt_i;
      OP_SRLI:  res = vi >> shamt_i;
      OP_SRAI:  res = 32'($signed(vi) >>> shamt_i);
      OP_ADD:   res = vi + vj;
      OP_SUB:   res = vi - vj;
      OP_SLL:   res = vi << shamt_r;
      OP_SLT:   res = {31'd0, $signed(vi) < $signed(vj)};
      OP_SLTU:  res = {31'd0, vi < vj};
      OP_XOR:   res = vi ^ vj;
      OP_SRL:   res = vi >> shamt_r;
      OP_SRA:   res = 32'($signed(vi) >>> shamt_r);
      OP_OR:    res = vi | vj;
      OP_AND:   res = vi & vj;
      default: begin
        // NOP, memory ops and unused codes: everything reads as zero.
        valid   = 1'b0;
        next_pc = '0;
      end
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - pipelined integer execution unit with registered result broadcast
//
// Parameter LATENCY: 1 = compute feeds the output register directly,
//                    2 = one extra stage register before the output register.
// Optional macro ALU_PERF_CNT_EN adds perf_ops / perf_br_taken counters.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   rdy             global enable; low freezes every register
//   flush           misprediction flush; clears all stages, drops the current input
//   in_op/in_vi/in_vj/in_imm/in_rob_id/in_pc   issued micro-op
//   out_valid/out_res/out_rob_id               result broadcast (zeros when not valid)
//   out_is_br/out_taken/out_next_pc            control-transfer resolution
//   perf_ops/perf_br_taken                     (ALU_PERF_CNT_EN only) broadcast and taken-branch counts
module alu_exec_unit
  import alu_exec_unit_pkg::*;
#(
  parameter int LATENCY = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                rdy,
  input  logic                flush,
  input  logic [OP_W-1:0]     in_op,
  input  logic [XLEN-1:0]     in_vi,
  input  logic [XLEN-1:0]     in_vj,
  input  logic [XLEN-1:0]     in_imm,
  input  logic [ROB_ID_W-1:0] in_rob_id,
  input  logic [XLEN-1:0]     in_pc,
  output logic                out_valid,
  output logic [XLEN-1:0]     out_res,
  output logic [ROB_ID_W-1:0] out_rob_id,
  output logic                out_is_br,
  output logic                out_taken,
  output logic [XLEN-1:0]     out_next_pc
`ifdef ALU_PERF_CNT_EN
  ,
  output logic [31:0]         perf_ops,
  output logic [31:0]         perf_br_taken
`endif
);

  alu_result_t comp;
  alu_result_t stage_d;
  alu_result_t out_q;

  logic [XLEN-1:0] c_res;
  logic            c_taken;
  logic [XLEN-1:0] c_next_pc;
  logic            c_is_br;
  logic            c_valid;

  alu_compute u_compute (
    .op      (in_op),
    .vi      (in_vi),
    .vj      (in_vj),
    .imm     (in_imm),
    .pc      (in_pc),
    .res     (c_res),
    .taken   (c_taken),
    .next_pc (c_next_pc),
    .is_br   (c_is_br),
    .valid   (c_valid)
  );

  // The tag is masked so an invalid slot carries no stale ROB id.
  assign comp.valid   = c_valid;
  assign comp.res     = c_res;
  assign comp.rob_id  = c_valid ? in_rob_id : '0;
  assign comp.is_br   = c_is_br;
  assign comp.taken   = c_taken;
  assign comp.next_pc = c_next_pc;

  generate
    if (LATENCY == 2) begin : g_lat2
      alu_result_t s1_q;
      always_ff @(posedge clk) begin
        if (rst || flush) begin
          s1_q <= '0;
        end else if (rdy) begin
          s1_q <= comp;
        end
      end
      assign stage_d = s1_q;
    end else begin : g_lat1
      assign stage_d = comp;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      out_q <= '0;
    end else if (rdy) begin
      out_q <= stage_d;
    end
  end

  assign out_valid   = out_q.valid;
  assign out_res     = out_q.res;
  assign out_rob_id  = out_q.rob_id;
  assign out_is_br   = out_q.is_br;
  assign out_taken   = out_q.taken;
  assign out_next_pc = out_q.next_pc;

`ifdef ALU_PERF_CNT_EN
  // Counted at the moment a valid result is loaded into the output register,
  // so a pulse held across a rdy-low stretch is counted once.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_ops      <= '0;
      perf_br_taken <= '0;
    end else if (rdy && !flush && stage_d.valid) begin
      perf_ops <= perf_ops + 32'd1;
      if (stage_d.is_br && stage_d.taken) begin
        perf_br_taken <= perf_br_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit at LATENCY 1 and 2
module tb_alu_exec_unit;

  typedef struct packed {
    bit        v;
    bit [31:0] res;
    bit [4:0]  rob;
    bit        br;
    bit        tk;
    bit [31:0] npc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rdy, flush;
  logic [6:0]  in_op;
  logic [31:0] in_vi, in_vj, in_imm, in_pc;
  logic [4:0]  in_rob_id;

  logic        o1_valid, o1_is_br, o1_taken;
  logic [31:0] o1_res, o1_npc;
  logic [4:0]  o1_rob;
  logic        o2_valid, o2_is_br, o2_taken;
  logic [31:0] o2_res, o2_npc;
  logic [4:0]  o2_rob;
`ifdef ALU_PERF_CNT_EN
  logic [31:0] p1_ops, p1_tk, p2_ops, p2_tk;
`endif

  alu_exec_unit #(.LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_op(in_op), .in_vi(in_vi), .in_vj(in_vj), .in_imm(in_imm),
    .in_rob_id(in_rob_id), .in_pc(in_pc),
    .out_valid(o1_valid), .out_res(o1_res), .out_rob_id(o1_rob),
    .out_is_br(o1_is_br), .out_taken(o1_taken), .out_next_pc(o1_npc)
`ifdef ALU_PERF_CNT_EN
    , .perf_ops(p1_ops), .perf_br_taken(p1_tk)
`endif
  );

  alu_exec_unit #(.LATENCY(2)) u_dut2 (
    .clk(clk), .rst(rst), .rdy(rdy), .flush(flush),
    .in_op(in_op), .in_vi(in_vi), .in_vj(in_vj), .in_imm(in_imm),
    .in_rob_id(in_rob_id), .in_pc(in_pc),
    .out_valid(o2_valid), .out_res(o2_res), .out_rob_id(o2_rob),
    .out_is_br(o2_is_br), .out_taken(o2_taken), .out_next_pc(o2_npc)
`ifdef ALU_PERF_CNT_EN
    , .perf_ops(p2_ops), .perf_br_taken(p2_tk)
`endif
  );

  int checks = 0;
  int failures = 0;

  // Reference state: what each unit should be showing, plus the LATENCY=2 in-flight slot.
  exp_t e1, e2, pend2;
  int unsigned m1_ops, m1_tk, m2_ops, m2_tk;

  function automatic exp_t ref_alu(int op, bit [31:0] a, bit [31:0] b, bit [31:0] imm,
                                   bit [31:0] pc, bit [4:0] tag);
    exp_t r;
    bit [31:0] seq, tgt;
    bit ok;
    bit c;
    r = '0;
    seq = pc + 32'd4;
    tgt = pc + imm;
    ok = 1'b1;
    r.npc = seq;
    if (op >= 5 && op <= 10) begin
      case (op)
        5:       c = (a == b);
        6:       c = (a != b);
        7:       c = $signed(a) < $signed(b);
        8:       c = !($signed(a) < $signed(b));
        9:       c = a < b;
        default: c = !(a < b);
      endcase
      r.br = 1'b1;
      r.tk = c;
      r.npc = c ? tgt : seq;
    end else begin
      case (op)
        1:  r.res = imm;
        2:  r.res = tgt;
        3:  begin r.res = seq; r.npc = tgt; r.tk = 1'b1; r.br = 1'b1; end
        4:  begin r.res = seq; r.npc = (a + imm) & 32'hFFFF_FFFE; r.tk = 1'b1; r.br = 1'b1; end
        19: r.res = a + imm;
        20: r.res = ($signed(a) < $signed(imm)) ? 32'd1 : 32'd0;
        21: r.res = (a < imm) ? 32'd1 : 32'd0;
        22: r.res = a ^ imm;
        23: r.res = a | imm;
        24: r.res = a & imm;
        25: r.res = a << (imm % 32);
        26: r.res = a >> (imm % 32);
        27: r.res = 32'($signed(a) >>> (imm % 32));
        28: r.res = a + b;
        29: r.res = a + ~b + 32'd1;
        30: r.res = a << (b % 32);
        31: r.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        32: r.res = (a < b) ? 32'd1 : 32'd0;
        33: r.res = a ^ b;
        34: r.res = a >> (b % 32);
        35: r.res = 32'($signed(a) >>> (b % 32));
        36: r.res = a | b;
        37: r.res = a & b;
        default: ok = 1'b0;
      endcase
    end
    if (!ok) return '0;
    r.v = 1'b1;
    r.rob = tag;
    return r;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("l1_valid", 32'(o1_valid), 32'(e1.v));
    chk("l1_res",   o1_res,        e1.res);
    chk("l1_rob",   32'(o1_rob),   32'(e1.rob));
    chk("l1_is_br", 32'(o1_is_br), 32'(e1.br));
    chk("l1_taken", 32'(o1_taken), 32'(e1.tk));
    chk("l1_npc",   o1_npc,        e1.npc);
    chk("l2_valid", 32'(o2_valid), 32'(e2.v));
    chk("l2_res",   o2_res,        e2.res);
    chk("l2_rob",   32'(o2_rob),   32'(e2.rob));
    chk("l2_is_br", 32'(o2_is_br), 32'(e2.br));
    chk("l2_taken", 32'(o2_taken), 32'(e2.tk));
    chk("l2_npc",   o2_npc,        e2.npc);
`ifdef ALU_PERF_CNT_EN
    chk("l1_perf_ops", p1_ops, m1_ops);
    chk("l1_perf_tk",  p1_tk,  m1_tk);
    chk("l2_perf_ops", p2_ops, m2_ops);
    chk("l2_perf_tk",  p2_tk,  m2_tk);
`endif
  endtask

  // One clock: advance the reference with the inputs the DUT samples, then compare.
  task automatic step();
    exp_t c;
    @(posedge clk);
    c = ref_alu(int'(in_op), in_vi, in_vj, in_imm, in_pc, in_rob_id);
    if (rst) begin
      e1 = '0; e2 = '0; pend2 = '0;
      m1_ops = 0; m1_tk = 0; m2_ops = 0; m2_tk = 0;
    end else if (flush) begin
      e1 = '0; e2 = '0; pend2 = '0;
    end else if (rdy) begin
      e1 = c;
      e2 = pend2;
      pend2 = c;
      if (e1.v) begin m1_ops++; if (e1.br && e1.tk) m1_tk++; end
      if (e2.v) begin m2_ops++; if (e2.br && e2.tk) m2_tk++; end
    end
    #1;
    check_all();
  endtask

  task automatic drive(int op, logic [31:0] a, logic [31:0] b, logic [31:0] imm,
                       logic [31:0] pc, logic [4:0] tag);
    in_op = 7'(op); in_vi = a; in_vj = b; in_imm = imm; in_pc = pc; in_rob_id = tag;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0:       return $urandom;
      1:       return $urandom_range(0, 40);
      2:       return 32'h8000_0000 | $urandom_range(0, 255);
      default: return 32'd0 - $urandom_range(1, 40);
    endcase
  endfunction

  initial begin
    int unsigned p_before;
    e1 = '0; e2 = '0; pend2 = '0;
    m1_ops = 0; m1_tk = 0; m2_ops = 0; m2_tk = 0;
    rst = 1'b1; rdy = 1'b1; flush = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    chk("rst_valid", 32'(o1_valid), 32'd0);
    chk("rst_npc",   o2_npc,        32'd0);
    rst = 1'b0;

    drive(28, 32'd5, 32'd7, 32'd0, 32'd0, 5'd3);
    step();
    chk("add_valid", 32'(o1_valid), 32'd1);
    chk("add_res",   o1_res,        32'd12);
    chk("add_rob",   32'(o1_rob),   32'd3);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("add_l1_drop", 32'(o1_valid), 32'd0);
    chk("add_l2_res",  o2_res,        32'd12);
    step();
    chk("add_l2_drop", 32'(o2_valid), 32'd0);

    drive(27, 32'h8000_0000, 32'd0, 32'd4, 32'd0, 5'd1);
    step();
    chk("srai_res", o1_res, 32'hF800_0000);
    drive(32, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 5'd2);
    step();
    chk("sltu_res", o1_res, 32'd1);
    chk("srai_l2",  o2_res, 32'hF800_0000);

    drive(6, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h100, 5'd4);
    step();
    chk("bne_is_br", 32'(o1_is_br), 32'd1);
    chk("bne_taken", 32'(o1_taken), 32'd1);
    chk("bne_npc",   o1_npc,        32'hF8);
    drive(5, 32'd1, 32'd2, 32'hFFFF_FFF8, 32'h100, 5'd5);
    step();
    chk("beq_taken", 32'(o1_taken), 32'd0);
    chk("beq_npc",   o1_npc,        32'h104);
    drive(4, 32'h203, 32'd0, 32'd0, 32'h40, 5'd6);
    step();
    chk("jalr_res",   o1_res,        32'h44);
    chk("jalr_npc",   o1_npc,        32'h202);
    chk("jalr_taken", 32'(o1_taken), 32'd1);

    drive(0, 0, 0, 0, 0, 0);
    step();
    step();
    drive(28, 32'd9, 32'd1, 32'd0, 32'd0, 5'd7);
    step();
    drive(0, 0, 0, 0, 0, 0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_l2_a", 32'(o2_valid), 32'd0);
    step();
    chk("flush_l2_b", 32'(o2_valid), 32'd0);

    drive(12, 32'd4, 32'd4, 32'd4, 32'h80, 5'd8);
    step();
    chk("load_l1", 32'(o1_valid), 32'd0);
    drive(0, 0, 0, 0, 0, 0);
    step();
    chk("load_l2", 32'(o2_valid), 32'd0);

    p_before = m2_ops;
    drive(28, 32'd100, 32'd23, 32'd0, 32'd0, 5'd9);
    step();
    drive(0, 0, 0, 0, 0, 0);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("frz_l1_res",   o1_res,        32'd123);
      chk("frz_l2_valid", 32'(o2_valid), 32'd0);
    end
    rdy = 1'b1;
    step();
    chk("frz_l2_out", o2_res, 32'd123);
    chk("frz_l2_rob", 32'(o2_rob), 32'd9);
`ifdef ALU_PERF_CNT_EN
    chk("frz_perf_once", p2_ops, 32'(p_before + 1));
`endif
    step();
    chk("frz_l2_once", 32'(o2_valid), 32'd0);

    for (int i = 0; i < 500; i++) begin
      logic [31:0] a;
      int op;
      rst   = ($urandom_range(0, 99) == 0);
      flush = ($urandom_range(0, 19) == 0);
      rdy   = ($urandom_range(0, 4) != 0);
      op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 127)) : int'($urandom_range(1, 37));
      a = pick();
      drive(op, a, ($urandom_range(0, 3) == 0) ? a : pick(), pick(),
            {$urandom_range(0, 32'h3FFF), 2'b00}, 5'($urandom_range(1, 31)));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
Name: alu_exec_unit

Overview:
- Integer execution unit at the issue end of the reservation-station-to-ALU interface.
- Consumes one issued micro-op per cycle: op code, operands, immediate, pc, and ROB tag.
- Computes the RV32I result and branch/jump resolution.
- Broadcasts a registered result (valid, result, ROB tag) that feeds the RS/LSB wakeup port and the ROB.

Parameters:
- LATENCY, 1, issue-to-broadcast latency in cycles; 1 = single output register, 2 = extra pipeline register before output; other values illegal.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; low freezes all state
- flush  in  1  misprediction flush from ROB
- in_op  in  7  issued op code; 0 = no op this cycle
- in_vi  in  32  operand 1 (rs1 value)
- in_vj  in  32  operand 2 (rs2 value)
- in_imm  in  32  sign-extended immediate
- in_rob_id  in  5  ROB tag of instruction (1-based; 0 never valid)
- in_pc  in  32  instruction pc
- out_valid  out  1  result broadcast valid
- out_res  out  32  result value
- out_rob_id  out  5  tag of broadcast result
- out_is_br  out  1  instruction is JAL/JALR/Bxx
- out_taken  out  1  control transfer taken
- out_next_pc  out  32  resolved next pc

Behaviour:
- Op codes (package): NOP 0, LUI 1, AUIPC 2, JAL 3, JALR 4, BEQ 5, BNE 6, BLT 7, BGE 8, BLTU 9, BGEU 10, 11-18 memory ops, ADDI 19, SLTI 20, SLTIU 21, XORI 22, ORI 23, ANDI 24, SLLI 25, SRLI 26, SRAI 27, ADD 28, SUB 29, SLL 30, SLT 31, SLTU 32, XOR 33, SRL 34, SRA 35, OR 36, AND 37.
- Input accepted every cycle; no backpressure. An op is valid when in_op is in 1..10 or 19..37.
- Codes 0, 11-18 and 38-127 produce no broadcast: stage valid = 0.
- Results:
  - LUI: imm.
  - AUIPC: pc+imm.
  - JAL: res = pc+4, next = pc+imm, taken = 1.
  - JALR: res = pc+4, next = (vi+imm) & ~1, taken = 1.
  - Bxx: res = 0, taken = compare(vi, vj), next = taken ? pc+imm : pc+4.
- I-type ops use vi with imm; shift amount = imm[4:0]. R-type ops use vi with vj; shift amount = vj[4:0].
- SLT/SLTI compare signed; SLTU/SLTIU/BLTU/BGEU compare unsigned. SLTIU compares against the sign-extended imm as unsigned.
- All arithmetic is 32-bit modulo 2^32; overflow is ignored.
- Non-branch ops: out_is_br = 0, out_taken = 0, out_next_pc = pc+4.
- LATENCY=1: outputs register the computed values; an op issued in cycle N broadcasts in cycle N+1.
- LATENCY=2: compute is registered into stage-1 and stage-1 moves to the outputs; broadcast in cycle N+2. Back-to-back ops stream at one per cycle.
- Priority: rst > flush > rdy.
  - rst: all outputs and internal stage registers go to 0.
  - flush: invalidates every stage, and out_valid = 0 next cycle. An op presented in the same cycle as flush is dropped.
  - rdy low: all registers hold value, and the input is ignored.
- Invalid cycle: out_valid = 0 and all other outputs are driven to 0, never stale.
- out_valid is high for exactly one cycle per accepted op.

Optional Feature:
- Macro ALU_PERF_CNT_EN.
- When defined, adds outputs perf_ops[31:0] and perf_br_taken[31:0].
  - perf_ops counts every out_valid pulse; perf_br_taken counts pulses with out_is_br && out_taken.
  - Both are cleared by rst only (not by flush), held when rdy is low, and wrap at 2^32.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- The op-code constants above, the ROB tag width (5), and the word width (32) belong in the shared const package, next to the RS sizing constants.
- One sub-module is natural: alu_compute, purely combinational op/vi/vj/imm/pc -> res, taken, next_pc, is_br, valid.
- alu_exec_unit keeps the pipeline registers, flush/rdy handling and the optional counters.

Test Plan:
- ADD vi=5, vj=7, tag 3 -> next cycle out_valid=1, res=12, rob_id=3; cycle after, out_valid=0.
- SRAI vi=0x80000000, imm=4; then SLTU vi=1, vj=0xFFFFFFFF -> res 0xF8000000 then 1, on consecutive cycles.
- BNE vi=1, vj=2, pc=0x100, imm=-8 -> is_br=1, taken=1, next_pc=0xF8. BEQ with the same operands -> taken=0, next_pc=0x104.
- JALR vi=0x203, imm=0, pc=0x40 -> res=0x44, next_pc=0x202, taken=1.
- LATENCY=2 with ADD issued and flush in the following cycle -> no broadcast. Op 12 (load) issued -> out_valid stays 0.
- rdy low for 3 cycles while a result is pending -> outputs frozen, then broadcast once when rdy returns. With ALU_PERF_CNT_EN, perf_ops increments exactly once.
